// File: rtl/crt_scanout_if.sv
// crt_scanout_if: framebuffer read port between the scanout engine and the SPRAM arbiter.
// Latency: fb_rd_data is valid the cycle after fb_rd_req && fb_rd_grant.
// Backpressure: the requester holds fb_rd_req and fb_rd_addr until the arbiter grants.
// Signals: fb_rd_req, fb_rd_addr (requester -> arbiter); fb_rd_grant, fb_rd_data (arbiter -> requester).
interface crt_scanout_if #(
   parameter int ADDR_BITS = 14
);
   logic                 fb_rd_req;
   logic [ADDR_BITS-1:0] fb_rd_addr;
   logic                 fb_rd_grant;
   logic [15:0]          fb_rd_data;

   modport master (
      output fb_rd_req,
      output fb_rd_addr,
      input  fb_rd_grant,
      input  fb_rd_data
   );

   modport slave (
      input  fb_rd_req,
      input  fb_rd_addr,
      output fb_rd_grant,
      output fb_rd_data
   );
endinterface

// File: rtl/crt_scanout.sv
// crt_scanout: 1-bit monochrome CRT raster engine; sync generation, framebuffer word prefetch, MSB-first pixel shift.
// Latency: every output is registered one clock after the scan position that produces it.
// Backpressure: a fetch waits on fb_rd_grant; a word missing at its load slot is shown as a zero word and flags underrun.
// Ports: clk_16mhz, reset (synchronous, active-high); fb (crt_scanout_if master: fb_rd_req/fb_rd_addr out,
//        fb_rd_grant/fb_rd_data in); hsync, vsync, video, frame_start, underrun (sticky until frame start) out.
module crt_scanout #(
   parameter int   ACTIVE_WIDTH   = 512,
   parameter int   ACTIVE_HEIGHT  = 342,
   parameter int   ACTIVE_XOFFSET = 192,
   parameter int   ACTIVE_YOFFSET = 48,
   parameter int   TOTAL_WIDTH    = 720,
   parameter int   TOTAL_HEIGHT   = 390,
   parameter int   HSYNC_END      = 294,
   parameter int   VSYNC_OFFSET   = 128,
   parameter int   VSYNC_LINES    = 6,
   parameter logic HSYNC_ACTIVE   = 1'b0,
   parameter logic VSYNC_ACTIVE   = 1'b0,
   parameter logic INVERT         = 1'b1,
   parameter logic IDLE_LEVEL     = 1'b1,
   parameter int   STRIDE         = 32,
   parameter int   ADDR_BITS      = 14
) (
   input  logic          clk_16mhz,
   input  logic          reset,
   crt_scanout_if.master fb,
   output logic          hsync,
   output logic          vsync,
   output logic          video,
   output logic          frame_start,
   output logic          underrun
);
   localparam int XW = $clog2(TOTAL_WIDTH);
   localparam int YW = $clog2(TOTAL_HEIGHT);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;

   logic [XW-1:0]        xscan;
   logic [YW-1:0]        yscan;
   logic [1:0]           state;
   logic [15:0]          buf_word;
   logic                 buf_valid;
   logic [15:0]          shift;
   logic [15:0]          shift_nxt;

   logic [XW-1:0]        xrel;
   logic [XW-1:0]        frel;
   logic [YW-1:0]        yrel;
   logic                 x_act;
   logic                 y_act;
   logic                 win;
   logic                 load;
   logic                 fetch;
   logic                 vs_on;
   logic                 origin;
   logic [ADDR_BITS-1:0] addr_nxt;

   // Window tests rely on unsigned wrap: positions left of / above the window
   // wrap to large values and fall outside the range compare.
   assign xrel   = xscan - XW'(ACTIVE_XOFFSET);
   assign frel   = xscan - XW'(ACTIVE_XOFFSET - 16);
   assign yrel   = yscan - YW'(ACTIVE_YOFFSET);
   assign x_act  = 32'(xrel) < ACTIVE_WIDTH;
   assign y_act  = 32'(yrel) < ACTIVE_HEIGHT;
   assign win    = x_act && y_act;
   assign load   = win && (xrel[3:0] == 4'd0);
   // Fetch of word w starts one word slot ahead of its load.
   assign fetch  = y_act && (32'(frel) < ACTIVE_WIDTH) && (frel[3:0] == 4'd0);
   assign origin = (xscan == '0) && (yscan == '0);
   assign addr_nxt = ADDR_BITS'(32'(yrel) * STRIDE + 32'(frel[XW-1:4]));

   always_comb begin
      vs_on = 1'b0;
      if (yscan == '0)
         vs_on = 32'(xscan) >= VSYNC_OFFSET;
      else if (32'(yscan) < VSYNC_LINES)
         vs_on = 1'b1;
      else if (32'(yscan) == VSYNC_LINES)
         vs_on = 32'(xscan) < VSYNC_OFFSET;
   end

   // The pixel for the current slot is taken from the post-load/post-shift
   // value so the first pixel of a word appears right after its load slot.
   always_comb begin
      shift_nxt = shift;
      if (load)
         shift_nxt = buf_valid ? buf_word : 16'h0000;
      else if (win)
         shift_nxt = {shift[14:0], 1'b0};
   end

   always_ff @(posedge clk_16mhz) begin
      if (reset) begin
         xscan         <= '0;
         yscan         <= '0;
         state         <= S_IDLE;
         buf_word      <= 16'h0000;
         buf_valid     <= 1'b0;
         shift         <= 16'h0000;
         hsync         <= ~HSYNC_ACTIVE;
         vsync         <= ~VSYNC_ACTIVE;
         video         <= IDLE_LEVEL;
         frame_start   <= 1'b0;
         underrun      <= 1'b0;
         fb.fb_rd_req  <= 1'b0;
         fb.fb_rd_addr <= '0;
      end else begin
         if (xscan == XW'(TOTAL_WIDTH - 1)) begin
            xscan <= '0;
            yscan <= (yscan == YW'(TOTAL_HEIGHT - 1)) ? '0 : yscan + YW'(1);
         end else begin
            xscan <= xscan + XW'(1);
         end

         hsync       <= (32'(xscan) < HSYNC_END) ? HSYNC_ACTIVE : ~HSYNC_ACTIVE;
         vsync       <= vs_on ? VSYNC_ACTIVE : ~VSYNC_ACTIVE;
         video       <= win ? (shift_nxt[15] ^ INVERT) : IDLE_LEVEL;
         frame_start <= origin;
         shift       <= shift_nxt;

         // Clear has priority over a simultaneous set.
         if (origin)
            underrun <= 1'b0;
         else if (load && !buf_valid)
            underrun <= 1'b1;

         if (load)
            buf_valid <= 1'b0;

         // A new fetch wins over everything. Otherwise, anything still in
         // flight at a load slot belongs to the word just loaded and is stale.
         if (fetch) begin
            state         <= S_REQ;
            fb.fb_rd_req  <= 1'b1;
            fb.fb_rd_addr <= addr_nxt;
         end else if (load) begin
            state        <= S_IDLE;
            fb.fb_rd_req <= 1'b0;
         end else begin
            case (state)
               S_REQ: begin
                  if (fb.fb_rd_grant) begin
                     state        <= S_WAIT;
                     fb.fb_rd_req <= 1'b0;
                  end
               end
               S_WAIT: begin
                  buf_word  <= fb.fb_rd_data;
                  buf_valid <= 1'b1;
                  state     <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_crt_scanout.sv
// tb_crt_scanout: directed bench for crt_scanout on a reduced raster (96x8 total, 48x4 active).
// Latency: outputs sampled 1 time unit after each rising edge; pos is the scan position they reflect.
// Backpressure: the bench arbiter grants every request except addresses marked in the starve mask.
module tb_crt_scanout;
   localparam int AW  = 48;
   localparam int AH  = 4;
   localparam int XO  = 24;
   localparam int YO  = 2;
   localparam int TW  = 96;
   localparam int TH  = 8;
   localparam int HSE = 20;
   localparam int VSO = 10;
   localparam int VSL = 2;
   localparam int STR = 5;
   localparam int AB  = 4;
   localparam int FRAME = TW * TH;

   logic clk_16mhz = 1'b0;
   logic reset     = 1'b1;
   logic hsync, vsync, video, frame_start, underrun;

   crt_scanout_if #(.ADDR_BITS(AB)) fb ();

   crt_scanout #(
      .ACTIVE_WIDTH(AW), .ACTIVE_HEIGHT(AH), .ACTIVE_XOFFSET(XO), .ACTIVE_YOFFSET(YO),
      .TOTAL_WIDTH(TW), .TOTAL_HEIGHT(TH), .HSYNC_END(HSE), .VSYNC_OFFSET(VSO),
      .VSYNC_LINES(VSL), .HSYNC_ACTIVE(1'b0), .VSYNC_ACTIVE(1'b0), .INVERT(1'b1),
      .IDLE_LEVEL(1'b1), .STRIDE(STR), .ADDR_BITS(AB)
   ) dut (
      .clk_16mhz   (clk_16mhz),
      .reset       (reset),
      .fb          (fb),
      .hsync       (hsync),
      .vsync       (vsync),
      .video       (video),
      .frame_start (frame_start),
      .underrun    (underrun)
   );

   always #5 clk_16mhz = ~clk_16mhz;

   int          vectors     = 0;
   int          miscompares = 0;
   int          pos         = -1;
   int          mode        = 0;
   logic [15:0] starve      = 16'h0000;
   int          vid_err     = 0;
   int          hs_low      = 0;
   int          vs_low      = 0;
   int          req_cnt     = 0;

   function automatic int P(input int f, input int y, input int x);
      return f * FRAME + y * TW + x;
   endfunction

   function automatic logic [15:0] data_of(input logic [AB-1:0] a);
      return (mode != 0) ? 16'h8001 : (16'h3C5A ^ {4{a}});
   endfunction

   // Expected pixel from raster geometry: word w of active line y holds
   // data from address y*STR+w, MSB first, inverted; idle level elsewhere.
   function automatic logic exp_video(input int p);
      int x, y, w, b;
      logic [AB-1:0] a;
      logic [15:0]   d;
      x = p % TW;
      y = (p / TW) % TH;
      if (x < XO || x >= XO + AW || y < YO || y >= YO + AH)
         return 1'b1;
      w = (x - XO) / 16;
      b = (x - XO) % 16;
      a = AB'(((y - YO) * STR + w) % (1 << AB));
      d = starve[a] ? 16'h0000 : data_of(a);
      return ~d[15 - b];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic zero_counts();
      vid_err = 0;
      hs_low  = 0;
      vs_low  = 0;
      req_cnt = 0;
   endtask

   // One clock: acts as arbiter/SPRAM and accumulates per-frame statistics.
   task automatic step();
      logic          g;
      logic [AB-1:0] a;
      logic          r;
      g = fb.fb_rd_req && fb.fb_rd_grant;
      a = fb.fb_rd_addr;
      r = reset;
      if (pos >= 0 && g) req_cnt++;
      @(posedge clk_16mhz);
      #1;
      pos = r ? -1 : pos + 1;
      fb.fb_rd_data = g ? data_of(a) : 16'hDEAD;
      if (pos >= 0) begin
         if (video !== exp_video(pos)) vid_err++;
         if (hsync === 1'b0) hs_low++;
         if (vsync === 1'b0) vs_low++;
      end
      fb.fb_rd_grant = ~starve[fb.fb_rd_addr];
   endtask

   task automatic goto(input int target);
      int n;
      n = 0;
      while (pos < target && n < 4 * FRAME) begin
         step();
         n++;
      end
      if (pos != target) check("goto_timeout", pos, target);
   endtask

   initial begin
      fb.fb_rd_grant = 1'b1;
      fb.fb_rd_data  = 16'hDEAD;
      reset = 1'b1;
      repeat (3) step();
      check("rst_hsync", hsync, 1'b1);
      check("rst_vsync", vsync, 1'b1);
      check("rst_video", video, 1'b1);
      check("rst_req", fb.fb_rd_req, 1'b0);
      check("rst_addr", fb.fb_rd_addr, 0);
      check("rst_underrun", underrun, 1'b0);
      check("rst_frame_start", frame_start, 1'b0);

      // Frame 0: free run, every request granted, pattern data.
      reset = 1'b0;
      goto(P(0, 0, 0));
      check("f0_frame_start", frame_start, 1'b1);
      check("f0_hsync_on", hsync, 1'b0);
      check("f0_vsync_pre", vsync, 1'b1);
      goto(P(0, 0, 1));
      check("f0_frame_start_pulse", frame_start, 1'b0);
      goto(P(0, 0, 9));
      check("vsync_before_edge", vsync, 1'b1);
      goto(P(0, 0, 10));
      check("vsync_assert", vsync, 1'b0);
      goto(P(0, 0, 19));
      check("hsync_last_low", hsync, 1'b0);
      goto(P(0, 0, 20));
      check("hsync_release", hsync, 1'b1);
      goto(P(0, 2, 7));
      check("req_before_first", fb.fb_rd_req, 1'b0);
      goto(P(0, 2, 8));
      check("first_req", fb.fb_rd_req, 1'b1);
      check("first_addr", fb.fb_rd_addr, 0);
      goto(P(0, 2, 9));
      check("vsync_last_low", vsync, 1'b0);
      goto(P(0, 2, 10));
      check("vsync_release", vsync, 1'b1);
      goto(P(0, 3, 40));
      check("line1_w2_req", fb.fb_rd_req, 1'b1);
      check("line1_w2_addr", fb.fb_rd_addr, 7);
      goto(P(0, 5, 24));
      check("addr_wrap_req", fb.fb_rd_req, 1'b1);
      check("addr_wrap_addr", fb.fb_rd_addr, 0);
      goto(P(0, 7, 95));
      check("f0_hsync_low_cycles", hs_low, 20 * TH);
      check("f0_vsync_low_cycles", vs_low, VSL * TW);
      check("f0_requests", req_cnt, 12);
      check("f0_video_errors", vid_err, 0);
      check("f0_underrun", underrun, 1'b0);

      // Frame 1: every word 16'h8001 -> groups read 0, fourteen 1s, 0.
      zero_counts();
      mode = 1;
      goto(P(1, 0, 0));
      check("f1_frame_start", frame_start, 1'b1);
      goto(P(1, 2, 24));
      check("f1_pix0", video, 1'b0);
      goto(P(1, 2, 25));
      check("f1_pix1", video, 1'b1);
      goto(P(1, 2, 38));
      check("f1_pix14", video, 1'b1);
      goto(P(1, 2, 39));
      check("f1_pix15", video, 1'b0);
      goto(P(1, 2, 40));
      check("f1_next_pix0", video, 1'b0);
      goto(P(1, 7, 95));
      check("f1_video_errors", vid_err, 0);
      check("f1_underrun", underrun, 1'b0);
      check("f1_requests", req_cnt, 12);

      // Frame 2: starve line 1 word 1 (address 6).
      zero_counts();
      mode = 0;
      starve = 16'h0040;
      goto(P(2, 3, 24));
      check("starve_req", fb.fb_rd_req, 1'b1);
      check("starve_addr", fb.fb_rd_addr, 6);
      goto(P(2, 3, 39));
      check("starve_req_held", fb.fb_rd_req, 1'b1);
      check("starve_addr_held", fb.fb_rd_addr, 6);
      check("underrun_before_deadline", underrun, 1'b0);
      goto(P(2, 3, 40));
      check("underrun_set", underrun, 1'b1);
      check("next_word_req", fb.fb_rd_req, 1'b1);
      check("next_word_addr", fb.fb_rd_addr, 7);
      check("starved_pixel", video, 1'b1);
      goto(P(2, 7, 95));
      check("underrun_sticky", underrun, 1'b1);
      check("f2_video_errors", vid_err, 0);
      check("f2_requests", req_cnt, 11);

      // Frame 3: underrun cleared at frame start, set again, then reset mid-request.
      zero_counts();
      starve = 16'h0084;
      goto(P(3, 0, 0));
      check("f3_frame_start", frame_start, 1'b1);
      check("underrun_cleared", underrun, 1'b0);
      goto(P(3, 2, 55));
      check("f3_underrun_pre", underrun, 1'b0);
      goto(P(3, 2, 56));
      check("f3_underrun_set", underrun, 1'b1);
      goto(P(3, 3, 43));
      check("pending_req", fb.fb_rd_req, 1'b1);
      check("pending_addr", fb.fb_rd_addr, 7);
      check("f3_video_errors", vid_err, 0);

      // Grant lands on the reset edge; its data arrives late and must be dropped.
      starve = 16'h0000;
      fb.fb_rd_grant = 1'b1;
      reset = 1'b1;
      step();
      check("mid_rst_hsync", hsync, 1'b1);
      check("mid_rst_vsync", vsync, 1'b1);
      check("mid_rst_video", video, 1'b1);
      check("mid_rst_req", fb.fb_rd_req, 1'b0);
      check("mid_rst_addr", fb.fb_rd_addr, 0);
      check("mid_rst_underrun", underrun, 1'b0);
      check("mid_rst_frame_start", frame_start, 1'b0);
      step();
      step();

      // Restart: starve address 0, so a stale buffer would hide the underrun.
      starve = 16'h0001;
      fb.fb_rd_grant = 1'b1;
      reset = 1'b0;
      zero_counts();
      goto(P(0, 0, 0));
      check("restart_frame_start", frame_start, 1'b1);
      goto(P(0, 2, 8));
      check("restart_first_req", fb.fb_rd_req, 1'b1);
      check("restart_first_addr", fb.fb_rd_addr, 0);
      goto(P(0, 2, 23));
      check("restart_underrun_pre", underrun, 1'b0);
      goto(P(0, 2, 24));
      check("restart_underrun", underrun, 1'b1);
      check("restart_starved_pixel", video, 1'b1);
      goto(P(0, 7, 95));
      check("restart_video_errors", vid_err, 0);
      check("restart_underrun_sticky", underrun, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
